mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter shared by the fetch (IF) and load/store (LS) ports.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate conflicting grants; otherwise LS always wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q, len_q;
  logic        owner_ls_q, signed_q;
  logic [31:0] addr_q, wdata_q, rbuf_q, mem_a_q, if_data_q, ls_rdata_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q, if_done_q, ls_done_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_ls_q;
`endif

  logic        grant_ls, stall;
  logic [2:0]  req_len, cnt_nxt;
  logic [31:0] grant_addr, rd_word, rd_ext;

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_ls = ls_req & (~if_req | ~last_ls_q);
`else
    grant_ls = ls_req;
`endif
    grant_addr = grant_ls ? ls_addr : if_addr;
    if (!grant_ls)              req_len = 3'd4;
    else if (ls_size == 2'b00)  req_len = 3'd1;
    else if (ls_size == 2'b01)  req_len = 3'd2;
    else                        req_len = 3'd4;
    cnt_nxt = cnt_q + 3'd1;
    stall   = (state_q == StWrite) & io_buffer_full & (addr_q[17:16] == 2'b11);
    // mem_din in read cycle k carries byte k-1; merge it so the last byte is usable at once
    rd_word = rbuf_q;
    rd_word[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
    case (len_q)
      3'd1:    rd_ext = {{24{signed_q & rd_word[7]}}, rd_word[7:0]};
      3'd2:    rd_ext = {{16{signed_q & rd_word[15]}}, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  assign mem_wr   = mem_wr_q & rdy & ~stall;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      owner_ls_q <= 1'b0;
      signed_q   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ls_q  <= 1'b0;
`endif
    end else if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (!flush && (if_req || ls_req)) begin
            owner_ls_q <= grant_ls;
            addr_q     <= grant_addr;
            mem_a_q    <= grant_addr;
            len_q      <= req_len;
            signed_q   <= grant_ls & ls_signed;
            wdata_q    <= ls_wdata;
            rbuf_q     <= 32'd0;
            cnt_q      <= 3'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ls_q  <= grant_ls;
`endif
            if (grant_ls && ls_wr) begin
              state_q    <= StWrite;
              mem_wr_q   <= 1'b1;
              mem_dout_q <= ls_wdata[7:0];
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (flush) begin
            state_q <= StIdle;
            mem_a_q <= 32'd0;
            cnt_q   <= 3'd0;
          end else begin
            if (cnt_q != 3'd0) rbuf_q <= rd_word;
            if (cnt_q == len_q) begin
              state_q <= StDone;
              mem_a_q <= 32'd0;
              if (owner_ls_q) begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= rd_ext;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= rd_word;
              end
            end else begin
              cnt_q   <= cnt_nxt;
              mem_a_q <= mem_a_q + 32'd1;
            end
          end
        end
        StWrite: begin
          if (!stall) begin
            if (cnt_nxt == len_q) begin
              state_q    <= StDone;
              mem_wr_q   <= 1'b0;
              mem_a_q    <= 32'd0;
              mem_dout_q <= 8'd0;
              ls_done_q  <= 1'b1;
              ls_rdata_q <= 32'd0;
            end else begin
              cnt_q      <= cnt_nxt;
              mem_a_q    <= mem_a_q + 32'd1;
              mem_dout_q <= wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
            end
          end
        end
        StDone: begin
          state_q   <= StIdle;
          cnt_q     <= 3'd0;
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level reference model, byte RAM and
// golden memory image; directed cases for fetch, loads, stores, IO stall, flush, arbitration.
module tb_mem_arbiter;
  logic        clk, rst, rdy, flush;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_signed, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  ram  [65536];
  logic [7:0]  gold [65536];
  int          n_vec, n_err, cyc;
  // reference model of the transaction in flight
  bit          busy, m_ls, m_wr, last_ls;
  int          m_n, m_e, m_gcyc, last_lat;
  logic [31:0] m_addr, m_wdata, m_exp;
  int          n_if_done, n_ls_done;
  logic [31:0] last_if_data, last_ls_data;
  logic [39:0] wlog [$];
  bit          grants [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input int n, input bit sgn);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) v |= 32'(gold[16'(addr + 32'(k))]) << (8 * k);
    if (sgn && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic poke(input logic [31:0] addr, input logic [7:0] b);
    ram[addr[15:0]]  = b;
    gold[addr[15:0]] = b;
  endtask

  // Check the current cycle against the model, advance the model across the next edge, clock.
  task automatic cycle();
    logic rd_ph, wr_ph, dn_ph, stall;
    bit dropi, dropl;
    logic [7:0] din_next;
    #1;
    rd_ph = busy && !m_wr && (m_e <= m_n);
    wr_ph = busy && m_wr && (m_e < m_n);
    dn_ph = busy && !rd_ph && !wr_ph;
    stall = wr_ph && io_buffer_full && (m_addr[17:16] == 2'b11);
    check_eq("if_done", 32'(if_done), 32'(dn_ph && !m_ls));
    check_eq("ls_done", 32'(ls_done), 32'(dn_ph && m_ls));
    check_eq("mem_wr", 32'(mem_wr), 32'(wr_ph && rdy && !stall));
    if (!(rd_ph && m_e == m_n))
      check_eq("mem_a", mem_a, (busy && !dn_ph) ? m_addr + 32'(m_e) : 32'd0);
    if (wr_ph) check_eq("mem_dout", 32'(mem_dout), 32'(m_wdata[8*m_e +: 8]));
    if (dn_ph && !m_ls) check_eq("if_data", if_data, m_exp);
    if (dn_ph && m_ls && !m_wr) check_eq("ls_rdata", ls_rdata, m_exp);
    if (if_done) begin n_if_done++; last_if_data = if_data; end
    if (ls_done) begin n_ls_done++; last_ls_data = ls_rdata; end
    if (mem_wr) wlog.push_back({mem_a, mem_dout});

    dropi = 0;
    dropl = 0;
    if (!rst) begin
      busy    = 0;
      last_ls = 0;
    end else if (rdy) begin
      if (!busy) begin
        if (!flush && (if_req || ls_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_ls = ls_req && (!if_req || !last_ls);
`else
          m_ls = ls_req;
`endif
          last_ls = m_ls;
          grants.push_back(m_ls);
          m_addr  = m_ls ? ls_addr : if_addr;
          m_wr    = m_ls && ls_wr;
          m_n     = !m_ls ? 4 : (ls_size == 2'b00) ? 1 : (ls_size == 2'b01) ? 2 : 4;
          m_wdata = ls_wdata;
          m_e     = 0;
          busy    = 1;
          m_gcyc  = cyc + 1;
          m_exp   = exp_load(m_addr, m_n, m_ls && ls_signed);
        end
      end else if (rd_ph) begin
        if (flush) busy = 0;
        else m_e++;
      end else if (wr_ph) begin
        if (!stall) begin
          gold[16'(m_addr + 32'(m_e))] = m_wdata[8*m_e +: 8];
          m_e++;
        end
      end else begin
        busy     = 0;
        last_lat = cyc + 1 - m_gcyc;
        if (m_ls) dropl = 1;
        else dropi = 1;
      end
    end

    // RAM shares the global enable: registered read, one cycle after its address
    if (mem_wr) ram[mem_a[15:0]] = mem_dout;
    din_next = rdy ? ram[mem_a[15:0]] : mem_din;
    @(posedge clk);
    #1;
    cyc++;
    mem_din = din_next;
    if (dropi) if_req = 1'b0;
    if (dropl) ls_req = 1'b0;
  endtask

  task automatic run_until_done(input string tag);
    int a0, k;
    a0 = n_if_done + n_ls_done;
    k  = 0;
    while (n_if_done + n_ls_done == a0 && k < 200) begin
      cycle();
      k++;
    end
    check_eq({tag, "_finished"}, 32'(n_if_done + n_ls_done - a0), 32'd1);
  endtask

  task automatic set_ls(input bit wr, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd);
    ls_wr = wr; ls_size = sz; ls_signed = sgn; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {14'd0, 2'b11, 16'($urandom)};
      1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    int nd;
    bit exp_ls;
    for (int i = 0; i < 65536; i++) begin
      ram[i]  = 8'($urandom);
      gold[i] = ram[i];
    end
    n_vec = 0; n_err = 0; cyc = 0; busy = 0; last_ls = 0; last_lat = 0;
    n_if_done = 0; n_ls_done = 0;
    mem_din = 8'd0; rst = 1'b0; rdy = 1'b0; flush = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
    ls_addr = 32'd0; ls_wdata = 32'd0;

    // reset takes effect even with rdy low
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_if_data", if_data, 32'd0);
    check_eq("rst_ls_rdata", ls_rdata, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    rdy = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();

    // word fetch
    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    if_addr = 32'h100;
    if_req  = 1'b1;
    run_until_done("fetch");
    check_eq("fetch_lat", 32'(last_lat), 32'd6);
    check_eq("fetch_data", last_if_data, 32'h0000_0013);

    // byte loads, signed and unsigned
    poke(32'h200, 8'h80);
    set_ls(1'b0, 2'b00, 1'b1, 32'h200, 32'd0);
    run_until_done("lb");
    check_eq("lb_data", last_ls_data, 32'hFFFF_FF80);
    check_eq("lb_lat", 32'(last_lat), 32'd3);
    set_ls(1'b0, 2'b00, 1'b0, 32'h200, 32'd0);
    run_until_done("lbu");
    check_eq("lbu_data", last_ls_data, 32'h0000_0080);

    // word store, little-endian byte order
    wlog.delete();
    w = 32'hDEAD_BEEF;
    set_ls(1'b1, 2'b10, 1'b0, 32'h300, w);
    run_until_done("sw");
    check_eq("sw_lat", 32'(last_lat), 32'd5);
    check_eq("sw_nwrites", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check_eq("sw_byte", 32'(wlog[i]), 32'({32'h300 + 32'(i), w[8*i +: 8]}));

    // IO store held off by a full UART buffer for three cycles
    wlog.delete();
    io_buffer_full = 1'b1;
    set_ls(1'b1, 2'b00, 1'b0, 32'h0003_0000, 32'h0000_005A);
    repeat (4) cycle();
    check_eq("io_stall_nowrite", 32'(wlog.size()), 32'd0);
    io_buffer_full = 1'b0;
    run_until_done("io_sb");
    check_eq("io_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() > 0) check_eq("io_byte", 32'(wlog[0]), 32'({32'h0003_0000, 8'h5A}));
    check_eq("io_lat", 32'(last_lat), 32'd5);

    // flush in the third read cycle of a fetch
    if_addr = 32'h400;
    if_req  = 1'b1;
    repeat (3) cycle();
    flush = 1'b1;
    nd = n_if_done;
    cycle();
    flush  = 1'b0;
    if_req = 1'b0;
    check_eq("flush_mem_a", mem_a, 32'd0);
    repeat (8) cycle();
    check_eq("flush_no_done", 32'(n_if_done - nd), 32'd0);

    // simultaneous requests straight after reset
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_addr = 32'h500;
      if_req  = 1'b1;
      set_ls(1'b0, 2'b00, 1'b0, 32'h600, 32'd0);
      nd = n_ls_done;
      run_until_done("conflict");
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_ls = (i % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      check_eq("conflict_owner", 32'(n_ls_done - nd), 32'(exp_ls));
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (8) cycle();

    // randomized traffic with stalls, flushes, freezes and occasional resets
    for (int t = 0; t < 4000; t++) begin
      rdy            = ($urandom_range(0, 7) != 0);
      flush          = ($urandom_range(0, 11) == 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      rst            = ($urandom_range(0, 299) != 0);
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = rand_addr();
      end
      if (!ls_req && $urandom_range(0, 3) == 0)
        set_ls(1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
